// File: rtl/fifo_sync_wr_adapter.sv
// Two-entry skid store between a valid/ready producer and a synchronous FIFO write port.
// Words drain one per cycle whenever the FIFO is not full, and word order is preserved.
module fifo_sync_wr_adapter #(
  parameter int DW            = 32,
  parameter int USE_PROG_FULL = 0,
  parameter int CW            = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] fifo_din,
  output logic          fifo_wr_en,
  input  logic          fifo_full,
  input  logic          fifo_prog_full,
  output logic [1:0]    occupancy,
  output logic [CW-1:0] wr_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] head_p0;
  logic [DW-1:0] tail_p1;
  logic [CW-1:0] wr_cnt;
  logic          pf_block;
  logic          accept;
  logic          drain;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Handshake decode uses only registered state and the FIFO flags, never in_valid.
  assign pf_block   = (USE_PROG_FULL != 0) && fifo_prog_full;
  assign in_ready   = (state != TWO) && !pf_block;
  assign accept     = in_valid && in_ready;
  assign fifo_wr_en = (state != EMPTY) && !fifo_full;
  assign drain      = fifo_wr_en;
  assign fifo_din   = head_p0;
  assign occupancy  = state;
  assign wr_count   = wr_cnt;

  // Stage p0 is the word presented to the FIFO; p1 holds the word queued behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      head_p0 <= '0;
      tail_p1 <= '0;
      wr_cnt  <= '0;
    end else begin
      if (drain) wr_cnt <= sat_inc(wr_cnt);
      case (state)
        EMPTY: begin
          if (accept) begin
            head_p0 <= in_data;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head_p0 <= in_data;
          end else if (accept) begin
            tail_p1 <= in_data;
            state   <= TWO;
          end else if (drain) begin
            state   <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            head_p0 <= tail_p1;
            state   <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sync_wr_adapter.sv
// Bench for fifo_sync_wr_adapter: three configurations (plain, prog_full throttled, 4-bit counter)
// share stimulus and are compared every cycle against an in-order list model.
module tb_fifo_sync_wr_adapter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        fifo_full = 1'b0;
  logic        fifo_prog_full = 1'b0;

  logic        rdy [3];
  logic        wen [3];
  logic [31:0] din [3];
  logic [1:0]  occ [3];
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic [3:0]  cnt2;

  fifo_sync_wr_adapter #(.DW(32), .USE_PROG_FULL(0), .CW(16)) dut_plain (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
    .fifo_din(din[0]), .fifo_wr_en(wen[0]), .fifo_full(fifo_full),
    .fifo_prog_full(fifo_prog_full), .occupancy(occ[0]), .wr_count(cnt0)
  );

  fifo_sync_wr_adapter #(.DW(32), .USE_PROG_FULL(1), .CW(16)) dut_pf (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
    .fifo_din(din[1]), .fifo_wr_en(wen[1]), .fifo_full(fifo_full),
    .fifo_prog_full(fifo_prog_full), .occupancy(occ[1]), .wr_count(cnt1)
  );

  fifo_sync_wr_adapter #(.DW(32), .USE_PROG_FULL(0), .CW(4)) dut_c4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[2]),
    .fifo_din(din[2]), .fifo_wr_en(wen[2]), .fifo_full(fifo_full),
    .fifo_prog_full(fifo_prog_full), .occupancy(occ[2]), .wr_count(cnt2)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: ordered list of held words, last presented word, saturating write count.
  int          pf_cfg [3] = '{0, 1, 0};
  int          max_cnt[3] = '{65535, 65535, 15};
  int          m_n    [3];
  logic [31:0] m_buf  [3][2];
  logic [31:0] m_din  [3];
  int          m_cnt  [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_cnt(input int i);
    if (i == 0) return {16'b0, cnt0};
    if (i == 1) return {16'b0, cnt1};
    return {28'b0, cnt2};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_n[i]      = 0;
      m_buf[i][0] = '0;
      m_buf[i][1] = '0;
      m_din[i]    = '0;
      m_cnt[i]    = 0;
    end
  endtask

  // Check all instances before the edge, advance the model, then cross the edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      logic e_rdy, e_wr, acc;
      e_rdy = (m_n[i] < 2) && !((pf_cfg[i] != 0) && fifo_prog_full);
      e_wr  = (m_n[i] > 0) && !fifo_full;
      chk($sformatf("in_ready[%0d]", i), {31'b0, rdy[i]}, {31'b0, e_rdy});
      chk($sformatf("wr_en[%0d]", i), {31'b0, wen[i]}, {31'b0, e_wr});
      chk($sformatf("din[%0d]", i), din[i], m_din[i]);
      chk($sformatf("occ[%0d]", i), {30'b0, occ[i]}, m_n[i]);
      chk($sformatf("wr_count[%0d]", i), obs_cnt(i), m_cnt[i]);
      if (rst) begin
        m_n[i] = 0; m_buf[i][0] = '0; m_buf[i][1] = '0; m_din[i] = '0; m_cnt[i] = 0;
      end else begin
        acc = in_valid && e_rdy;
        if (e_wr) begin
          if (m_cnt[i] < max_cnt[i]) m_cnt[i]++;
          m_buf[i][0] = m_buf[i][1];
          m_n[i]--;
        end
        if (acc) begin
          m_buf[i][m_n[i]] = in_data;
          m_n[i]++;
        end
        if (m_n[i] > 0) m_din[i] = m_buf[i][0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic full, input logic pf);
    in_valid       = v;
    in_data        = d;
    fifo_full      = full;
    fifo_prog_full = pf;
    step();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    rst = 1'b0;

    // Single word, latency one
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("wr_count_one", {16'b0, cnt0}, 32'd1);

    // Back-to-back stream
    for (int k = 1; k <= 8; k++) drive(1'b1, k, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("wr_count_stream", {16'b0, cnt0}, 32'd9);

    // Backpressure from full, then release
    drive(1'b1, 32'hA, 1'b1, 1'b0);
    drive(1'b1, 32'hB, 1'b1, 1'b0);
    drive(1'b1, 32'hC, 1'b1, 1'b0);
    drive(1'b1, 32'hC, 1'b1, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Programmable-full throttling
    drive(1'b1, 32'h36, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'h37, 1'b0, 1'b1);
    repeat (2) drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset with two words held
    drive(1'b1, 32'h1, 1'b1, 1'b0);
    drive(1'b1, 32'h2, 1'b1, 1'b0);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("wr_count_after_rst", {16'b0, cnt0}, 32'd0);

    // Counter saturation on the 4-bit instance
    for (int k = 0; k < 20; k++) drive(1'b1, 32'h100 + k, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("cnt_sat_c4", {28'b0, cnt2}, 32'd15);
    chk("cnt_20_plain", {16'b0, cnt0}, 32'd20);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) < 3,
            $urandom_range(0, 3) == 0);
    end
    rst = 1'b0;
    repeat (4) drive(1'b0, 32'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
